vec_proc_core: RTL

//  Parametrised successor of the two-opcode load/store vector processor: register file plus local

---
 rtl/vproc_pkg.sv | 30 +++
 rtl/vproc_regfile.sv | 49 ++++
 rtl/vec_proc_core.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vproc_pkg.sv
// Shared types for the vector processor core: opcode and FSM state encodings.
package vproc_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_MUL   = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Opcodes that walk the element counter (everything legal except NOP).
  function automatic logic op_is_exec(input logic [OPC_W-1:0] op);
    return (op >= OPC_W'(OP_LOAD)) && (op <= OPC_W'(OP_MUL));
  endfunction

  function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
    return op <= OPC_W'(OP_MUL);
  endfunction

endpackage

// File: rtl/vproc_regfile.sv
// Vector register file: two element read ports for the ALU, one debug read port,
// one element write port, all registers cleared by async active-low reset.
module vproc_regfile #(
  parameter  int NUM_VREGS = 4,
  parameter  int NUM_ELEMS = 16,
  parameter  int ELEM_W    = 32,
  localparam int VRW       = $clog2(NUM_VREGS),
  localparam int EW        = $clog2(NUM_ELEMS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [VRW-1:0]    i_wr_vreg,
  input  logic [EW-1:0]     i_wr_elem,
  input  logic [ELEM_W-1:0] i_wr_data,
  input  logic [VRW-1:0]    i_rd_a_vreg,
  input  logic [EW-1:0]     i_rd_a_elem,
  output logic [ELEM_W-1:0] o_rd_a_data,
  input  logic [VRW-1:0]    i_rd_b_vreg,
  input  logic [EW-1:0]     i_rd_b_elem,
  output logic [ELEM_W-1:0] o_rd_b_data,
  input  logic [VRW-1:0]    i_dbg_vreg,
  input  logic [EW-1:0]     i_dbg_elem,
  output logic [ELEM_W-1:0] o_dbg_data
);

  logic [ELEM_W-1:0] r_vreg [NUM_VREGS][NUM_ELEMS];

  // Element write port with full clear on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int v = 0; v < NUM_VREGS; v++) begin
        for (int e = 0; e < NUM_ELEMS; e++) begin
          r_vreg[v][e] <= '0;
        end
      end
    end else if (i_we) begin
      r_vreg[i_wr_vreg][i_wr_elem] <= i_wr_data;
    end
  end

  // Combinational reads; a same-cycle write is seen only after the edge.
  always_comb begin
    o_rd_a_data = r_vreg[i_rd_a_vreg][i_rd_a_elem];
    o_rd_b_data = r_vreg[i_rd_b_vreg][i_rd_b_elem];
    o_dbg_data  = r_vreg[i_dbg_vreg][i_dbg_elem];
  end

endmodule

// File: rtl/vec_proc_core.sv
// Vector execution unit: register file, local data memory, element-serial
// LOAD/STORE/ADD/SUB/MUL under a three-process sequencing FSM.
// Build option: define VPROC_SAT_EN to make ADD/SUB saturate as signed values.
//
// state  | meaning
// S_IDLE | ready for an instruction
// S_EXEC | one element per cycle, counter 0..NUM_ELEMS-1
// S_DONE | retire: done pulse (err for illegal), final LOAD element written
module vec_proc_core
  import vproc_pkg::*;
#(
  parameter  int NUM_VREGS = 4,
  parameter  int VLEN      = 512,
  parameter  int ELEM_W    = 32,
  parameter  int MEM_DEPTH = 512,
  localparam int NUM_ELEMS = VLEN / ELEM_W,
  localparam int VRW       = $clog2(NUM_VREGS),
  localparam int EW        = $clog2(NUM_ELEMS),
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OPC_W-1:0]  op_code,
  input  logic [VRW-1:0]    vd,
  input  logic [VRW-1:0]    vs1,
  input  logic [VRW-1:0]    vs2,
  input  logic [AW-1:0]     mem_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [VRW-1:0]    dbg_vreg,
  input  logic [EW-1:0]     dbg_elem,
  output logic [ELEM_W-1:0] dbg_data
);

  state_e            r_state, w_state_nxt;
  logic [OPC_W-1:0]  r_op;
  logic [VRW-1:0]    r_vd, r_vs1, r_vs2;
  logic [AW-1:0]     r_addr;
  logic              r_illegal;
  logic [EW-1:0]     r_cnt;
  logic              r_ld_vld;
  logic [EW-1:0]     r_ld_idx;
  logic [ELEM_W-1:0] r_mem [MEM_DEPTH];
  logic [ELEM_W-1:0] r_rd_data;

  logic              w_accept, w_last, w_st_we, w_alu_we;
  logic [AW-1:0]     w_mem_addr;
  logic [ELEM_W-1:0] w_rd_a, w_rd_b, w_alu;
  logic              w_rf_we;
  logic [EW-1:0]     w_rf_elem;
  logic [ELEM_W-1:0] w_rf_data;

  assign w_accept   = instr_valid && (r_state == S_IDLE);
  assign w_last     = (r_cnt == EW'(NUM_ELEMS - 1));
  assign w_mem_addr = r_addr + AW'(r_cnt);
  assign w_st_we    = (r_state == S_EXEC) && (r_op == OP_STORE);
  assign w_alu_we   = (r_state == S_EXEC) &&
                      ((r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_MUL));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; NOP and illegal opcodes go straight to retire.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = op_is_exec(op_code) ? S_EXEC : S_DONE;
      S_EXEC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    instr_ready = (r_state == S_IDLE);
    busy        = (r_state == S_EXEC) || (r_state == S_DONE);
    done        = (r_state == S_DONE);
    err         = (r_state == S_DONE) && r_illegal;
  end

  // Capture the instruction fields on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op      <= '0;
      r_vd      <= '0;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_addr    <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_op      <= op_code;
      r_vd      <= vd;
      r_vs1     <= vs1;
      r_vs2     <= vs2;
      r_addr    <= mem_addr;
      r_illegal <= !op_is_legal(op_code);
    end
  end

  // Element counter, restarted on every accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_cnt <= '0;
    else if (w_accept)           r_cnt <= '0;
    else if (r_state == S_EXEC)  r_cnt <= r_cnt + 1'b1;
  end

  // LOAD write-back trails the synchronous memory read by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_vld <= 1'b0;
      r_ld_idx <= '0;
    end else begin
      r_ld_vld <= (r_state == S_EXEC) && (r_op == OP_LOAD);
      r_ld_idx <= r_cnt;
    end
  end

  // Data memory: contents survive reset; address wraps at MEM_DEPTH.
  always_ff @(posedge clk) begin
    if (w_st_we) r_mem[w_mem_addr] <= w_rd_a;
    r_rd_data <= r_mem[w_mem_addr];
  end

`ifdef VPROC_SAT_EN
  localparam logic [ELEM_W-1:0] SAT_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] SAT_MIN = {1'b1, {(ELEM_W-1){1'b0}}};
  logic [ELEM_W:0] w_sum, w_dif;
  assign w_sum = {w_rd_a[ELEM_W-1], w_rd_a} + {w_rd_b[ELEM_W-1], w_rd_b};
  assign w_dif = {w_rd_a[ELEM_W-1], w_rd_a} - {w_rd_b[ELEM_W-1], w_rd_b};
`endif

  // Element ALU; the two top bits of the widened result disagree on signed overflow.
  always_comb begin
    w_alu = '0;
    case (r_op)
`ifdef VPROC_SAT_EN
      OP_ADD:  w_alu = (w_sum[ELEM_W] != w_sum[ELEM_W-1]) ?
                       (w_sum[ELEM_W] ? SAT_MIN : SAT_MAX) : w_sum[ELEM_W-1:0];
      OP_SUB:  w_alu = (w_dif[ELEM_W] != w_dif[ELEM_W-1]) ?
                       (w_dif[ELEM_W] ? SAT_MIN : SAT_MAX) : w_dif[ELEM_W-1:0];
`else
      OP_ADD:  w_alu = w_rd_a + w_rd_b;
      OP_SUB:  w_alu = w_rd_a - w_rd_b;
`endif
      OP_MUL:  w_alu = w_rd_a * w_rd_b;
      default: w_alu = '0;
    endcase
  end

  // Register-file write port shared by LOAD write-back and ALU results.
  always_comb begin
    w_rf_we   = r_ld_vld || w_alu_we;
    w_rf_elem = r_ld_vld ? r_ld_idx : r_cnt;
    w_rf_data = r_ld_vld ? r_rd_data : w_alu;
  end

  vproc_regfile #(
    .NUM_VREGS (NUM_VREGS),
    .NUM_ELEMS (NUM_ELEMS),
    .ELEM_W    (ELEM_W)
  ) u_regfile (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_we        (w_rf_we),
    .i_wr_vreg   (r_vd),
    .i_wr_elem   (w_rf_elem),
    .i_wr_data   (w_rf_data),
    .i_rd_a_vreg (r_vs1),
    .i_rd_a_elem (r_cnt),
    .o_rd_a_data (w_rd_a),
    .i_rd_b_vreg (r_vs2),
    .i_rd_b_elem (r_cnt),
    .o_rd_b_data (w_rd_b),
    .i_dbg_vreg  (dbg_vreg),
    .i_dbg_elem  (dbg_elem),
    .o_dbg_data  (dbg_data)
  );

endmodule
